// File: rtl/load_store_queue.sv
// In-order load/store queue between the execute stage and the data-memory bus.
// Latency: an entry pushed at edge N may request in the next cycle; load write-back lands one edge after dvalid_i.
// Backpressure: full_o stalls the ex stage; dack_i low holds the head; at most one load is outstanding.
//
// Ports:
//   clk_i, resetb_i, clk_en_i            clock, async active-low reset, global enable (low = all state holds)
//   lq_wr_i/sq_wr_i, hpl_i, funct3_i,    push side from ex stage; full_o = DEPTH entries held
//   regd_addr_i, regs2_data_i, addr_i
//   dreq_o/dack_i, dwr_o, daddr_o,       memory request bus, driven combinationally from the head entry
//   dbe_o, dwdata_o, dhpl_o
//   dvalid_i, drdata_i                   load response
//   reg_wr_o, reg_addr_o, reg_data_o     registered register-file write-back
module load_store_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        clk_en_i,
  output logic        full_o,
  input  logic        lq_wr_i,
  input  logic        sq_wr_i,
  input  logic [1:0]  hpl_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  regd_addr_i,
  input  logic [31:0] regs2_data_i,
  input  logic [31:0] addr_i,
  output logic        dreq_o,
  input  logic        dack_i,
  output logic        dwr_o,
  output logic [31:0] daddr_o,
  output logic [3:0]  dbe_o,
  output logic [31:0] dwdata_o,
  output logic [1:0]  dhpl_o,
  input  logic        dvalid_i,
  input  logic [31:0] drdata_i,
  output logic        reg_wr_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic        is_load;
    logic [1:0]  hpl;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
  } entry_t;

  typedef enum logic {ISSUE, WAIT} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        new_entry;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  state_t        state, state_nxt;
  logic          pop, push, wb;
  logic          is_byte, is_half;
  logic [1:0]    lane;
  logic [31:0]   shifted;
  logic [31:0]   ld_data;

  assign head   = mem[rd_ptr];
  assign full_o = (count == FULL_CNT);

  // A push while full is only accepted when the head leaves in the same cycle.
  assign push = (lq_wr_i | sq_wr_i) & (~full_o | pop);

  assign new_entry = '{is_load: lq_wr_i, hpl: hpl_i, funct3: funct3_i,
                       rd: regd_addr_i, data: regs2_data_i, addr: addr_i};

  always_comb begin
    state_nxt = state;
    dreq_o    = 1'b0;
    pop       = 1'b0;
    wb        = 1'b0;
    case (state)
      ISSUE: begin
        dreq_o = (count != '0);
        if (dreq_o && dack_i) begin
          if (head.is_load) state_nxt = WAIT;   // head stays until the response
          else              pop       = 1'b1;
        end
      end
      WAIT: begin
        if (dvalid_i) begin
          pop       = 1'b1;
          wb        = 1'b1;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = ISSUE;
    endcase
  end

  // Size decode: 100/101 are only byte/half for loads; every other
  // undefined encoding falls through to word.
  assign lane    = head.addr[1:0];
  assign is_byte = (head.funct3 == 3'b000) || (head.is_load && head.funct3 == 3'b100);
  assign is_half = (head.funct3 == 3'b001) || (head.is_load && head.funct3 == 3'b101);

  assign dwr_o   = ~head.is_load;
  assign daddr_o = {head.addr[31:2], 2'b00};
  assign dhpl_o  = head.hpl;

  always_comb begin
    if (is_byte) begin
      dbe_o    = 4'b0001 << lane;
      dwdata_o = {4{head.data[7:0]}};
    end else if (is_half) begin
      dbe_o    = 4'b0011 << lane;
      dwdata_o = {2{head.data[15:0]}};
    end else begin
      dbe_o    = 4'b1111;
      dwdata_o = head.data;
    end
  end

  assign shifted = drdata_i >> {lane, 3'b000};

  always_comb begin
    case (head.funct3)
      3'b000:  ld_data = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clk_en_i && push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state      <= ISSUE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      reg_wr_o   <= 1'b0;
      reg_addr_o <= '0;
      reg_data_o <= '0;
    end else if (clk_en_i) begin
      state    <= state_nxt;
      reg_wr_o <= wb;
      if (wb) begin
        reg_addr_o <= head.rd;
        reg_data_o <= ld_data;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;

  logic        clk = 1'b0;
  logic        resetb, clk_en, full, lq_wr, sq_wr;
  logic [1:0]  hpl;
  logic [2:0]  funct3;
  logic [4:0]  regd_addr;
  logic [31:0] regs2_data, addr;
  logic        dreq, dack, dwr;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dbe;
  logic [1:0]  dhpl;
  logic        dvalid;
  logic [31:0] drdata;
  logic        reg_wr;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_queue #(.DEPTH(4)) dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en), .full_o(full),
    .lq_wr_i(lq_wr), .sq_wr_i(sq_wr), .hpl_i(hpl), .funct3_i(funct3),
    .regd_addr_i(regd_addr), .regs2_data_i(regs2_data), .addr_i(addr),
    .dreq_o(dreq), .dack_i(dack), .dwr_o(dwr), .daddr_o(daddr), .dbe_o(dbe),
    .dwdata_o(dwdata), .dhpl_o(dhpl), .dvalid_i(dvalid), .drdata_i(drdata),
    .reg_wr_o(reg_wr), .reg_addr_o(reg_addr), .reg_data_o(reg_data)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] data;   // store data, or load response word
    logic [3:0]  be;
    logic [31:0] exp;    // expected dwdata (store) or reg_data (load)
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at the falling edge, after one rising edge has passed.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_op(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] d);
    lq_wr      = ld;
    sq_wr      = ~ld;
    funct3     = f3;
    regd_addr  = rd;
    addr       = a;
    regs2_data = d;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 5'd0,  32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 3'b000, 5'd5,  32'h0000_0203, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 3'b101, 5'd7,  32'h0000_0012, 32'hABCD_0000, 4'b1100, 32'h0000_ABCD};
    vecs[3]  = '{1'b0, 3'b000, 5'd0,  32'h0000_0041, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5};
    vecs[4]  = '{1'b0, 3'b001, 5'd0,  32'h0000_0042, 32'h7777_BEEF, 4'b1100, 32'hBEEF_BEEF};
    vecs[5]  = '{1'b1, 3'b001, 5'd10, 32'h0000_0300, 32'h0000_F00D, 4'b0011, 32'hFFFF_F00D};
    vecs[6]  = '{1'b1, 3'b100, 5'd11, 32'h0000_0301, 32'h0000_C300, 4'b0010, 32'h0000_00C3};
    vecs[7]  = '{1'b1, 3'b010, 5'd12, 32'h0000_0400, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF};
    vecs[8]  = '{1'b1, 3'b011, 5'd13, 32'h0000_0500, 32'h1357_2468, 4'b1111, 32'h1357_2468};
    vecs[9]  = '{1'b0, 3'b111, 5'd0,  32'h0000_0600, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
    vecs[10] = '{1'b1, 3'b000, 5'd31, 32'h0000_0601, 32'h0000_7F00, 4'b0010, 32'h0000_007F};

    resetb = 1'b0; clk_en = 1'b1; lq_wr = 1'b0; sq_wr = 1'b0; hpl = 2'd0;
    funct3 = 3'd0; regd_addr = 5'd0; regs2_data = '0; addr = '0;
    dack = 1'b0; dvalid = 1'b0; drdata = '0;
    tick();
    tick();
    #1;
    check("rst_full",     32'(full),     32'd0);
    check("rst_dreq",     32'(dreq),     32'd0);
    check("rst_reg_wr",   32'(reg_wr),   32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_data", reg_data,      32'd0);
    resetb = 1'b1;
    tick();

    // Table of single operations: lane placement, replication, extension.
    for (int i = 0; i < 11; i++) begin
      drive_op(vecs[i].ld, vecs[i].f3, vecs[i].rd, vecs[i].addr, vecs[i].data);
      hpl = 2'(i);
      tick();
      lq_wr = 1'b0; sq_wr = 1'b0;
      #1;
      check($sformatf("v%0d_dreq", i),  32'(dreq), 32'd1);
      check($sformatf("v%0d_dwr", i),   32'(dwr),  32'(!vecs[i].ld));
      check($sformatf("v%0d_daddr", i), daddr,     vecs[i].addr & 32'hFFFF_FFFC);
      check($sformatf("v%0d_dbe", i),   32'(dbe),  32'(vecs[i].be));
      check($sformatf("v%0d_dhpl", i),  32'(dhpl), 32'(i % 4));
      if (!vecs[i].ld) check($sformatf("v%0d_dwdata", i), dwdata, vecs[i].exp);
      dack = 1'b1;
      tick();
      dack = 1'b0;
      #1;
      check($sformatf("v%0d_dreq_after", i), 32'(dreq), 32'd0);
      check($sformatf("v%0d_full", i),       32'(full), 32'd0);
      if (vecs[i].ld) begin
        check($sformatf("v%0d_no_early_wb", i), 32'(reg_wr), 32'd0);
        drdata = vecs[i].data;
        dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        #1;
        check($sformatf("v%0d_reg_wr", i),   32'(reg_wr),   32'd1);
        check($sformatf("v%0d_reg_addr", i), 32'(reg_addr), 32'(vecs[i].rd));
        check($sformatf("v%0d_reg_data", i), reg_data,      vecs[i].exp);
        tick();
        #1;
        check($sformatf("v%0d_reg_wr_pulse", i), 32'(reg_wr), 32'd0);
      end
    end

    // Fill with dack low; fifth push is dropped; drain at one per cycle.
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b0, 3'b010, 5'd0, 32'h10 * i, 32'(i + 1));
      tick();
    end
    #1;
    check("fill_full", 32'(full), 32'd1);
    regs2_data = 32'd5;
    tick();
    sq_wr = 1'b0;
    #1;
    check("fill_full_5th", 32'(full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      dack = 1'b1;
      check($sformatf("drain%0d_dreq", k),   32'(dreq), 32'd1);
      check($sformatf("drain%0d_dwdata", k), dwdata,    32'(k + 1));
      check($sformatf("drain%0d_full", k),   32'(full), 32'(k == 0));
      tick();
      #1;
    end
    check("drain_empty", 32'(dreq), 32'd0);
    dack = 1'b0;

    // Full queue: push coincides with a store pop; order kept across wrap.
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b0, 3'b010, 5'd0, 32'h20, 32'hA0 + 32'(i));
      tick();
    end
    regs2_data = 32'hA4;
    dack = 1'b1;
    #1;
    check("pp_full_before", 32'(full), 32'd1);
    check("pp_head",        dwdata,    32'hA0);
    tick();
    sq_wr = 1'b0;
    dack  = 1'b0;
    #1;
    check("pp_full_after", 32'(full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      dack = 1'b1;
      check($sformatf("pp%0d_dwdata", k), dwdata, 32'hA1 + 32'(k));
      tick();
      #1;
    end
    check("pp_empty", 32'(dreq), 32'd0);
    dack = 1'b0;

    // Push during WAIT: the new store waits behind the outstanding load.
    drive_op(1'b1, 3'b010, 5'd9, 32'h700, 32'd0);
    tick();
    lq_wr = 1'b0;
    dack  = 1'b1;
    tick();
    dack = 1'b0;
    drive_op(1'b0, 3'b000, 5'd0, 32'h702, 32'h0000_005A);
    tick();
    sq_wr = 1'b0;
    #1;
    check("wait_push_noreq", 32'(dreq), 32'd0);
    drdata = 32'h1122_3344;
    dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    #1;
    check("wait_push_reg_data", reg_data,  32'h1122_3344);
    check("wait_push_reg_addr", 32'(reg_addr), 32'd9);
    check("wait_push_dreq",     32'(dreq), 32'd1);
    check("wait_push_dwr",      32'(dwr),  32'd1);
    check("wait_push_dbe",      32'(dbe),  32'b0100);
    check("wait_push_dwdata",   dwdata,    32'h5A5A_5A5A);
    dack = 1'b1;
    tick();
    dack = 1'b0;
    #1;
    check("wait_push_empty", 32'(dreq), 32'd0);

    // Clock enable low freezes the queue even with dack high.
    drive_op(1'b0, 3'b010, 5'd0, 32'h900, 32'h55);
    tick();
    sq_wr  = 1'b0;
    clk_en = 1'b0;
    dack   = 1'b1;
    tick();
    tick();
    #1;
    check("clk_en_hold", 32'(dreq), 32'd1);
    clk_en = 1'b1;
    tick();
    dack = 1'b0;
    #1;
    check("clk_en_resume", 32'(dreq), 32'd0);

    // Reset while a load is outstanding; the late response is ignored.
    drive_op(1'b1, 3'b010, 5'd3, 32'h800, 32'd0);
    tick();
    lq_wr = 1'b0;
    dack  = 1'b1;
    tick();
    dack = 1'b0;
    #1;
    check("rst_mid_wait", 32'(dreq), 32'd0);
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    drdata = 32'hFFFF_FFFF;
    dvalid = 1'b1;
    tick();
    dvalid = 1'b0;
    #1;
    check("rst_mid_reg_wr", 32'(reg_wr), 32'd0);
    check("rst_mid_dreq",   32'(dreq),   32'd0);
    check("rst_mid_full",   32'(full),   32'd0);
    tick();
    #1;
    check("rst_mid_reg_wr2", 32'(reg_wr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
